// File: rtl/minesweeper_ctrl_if.sv
// rtl/minesweeper_ctrl_if.sv - key inputs, board grids and display strobes of the minesweeper controller
interface minesweeper_ctrl_if #(
  parameter int N = 9
);
  localparam int FCW = $clog2(N + 1);

  logic           confirm;
  logic           flag;
  logic           restart;
  logic           readkey;
  logic [3:0]     udlr;
  logic [1:0]     wl;
  logic [N-1:0]   bombGrid;
  logic [N-1:0]   revealGrid;
  logic [N-1:0]   flagGrid;
  logic [N-1:0]   cursorGrid;
  logic [FCW-1:0] flag_count;
  logic           d_enable;
  logic           d_cursor;
  logic           d_reveal;
  logic [3:0]     cs;

  modport master (
    output confirm, flag, restart, readkey, udlr,
    input  wl, bombGrid, revealGrid, flagGrid, cursorGrid, flag_count,
    input  d_enable, d_cursor, d_reveal, cs
  );

  modport slave (
    input  confirm, flag, restart, readkey, udlr,
    output wl, bombGrid, revealGrid, flagGrid, cursorGrid, flag_count,
    output d_enable, d_cursor, d_reveal, cs
  );
endinterface

// File: rtl/minesweeper_ctrl.sv
// rtl/minesweeper_ctrl.sv - minesweeper game controller: LFSR bomb deal, cursor, reveal/flag, win/lose
module minesweeper_ctrl #(
  parameter int          GRID_W     = 3,
  parameter int          GRID_H     = 3,
  parameter int          BOMB_COUNT = 2,
  parameter int          WRAP       = 0,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input logic               clk_i,
  input logic               rst_ni,
  minesweeper_ctrl_if.slave bus
);
  localparam int N   = GRID_W * GRID_H;
  localparam int IW  = $clog2(N);
  localparam int FCW = $clog2(N + 1);
  localparam int XW  = $clog2(GRID_W);
  localparam int YW  = $clog2(GRID_H);

  typedef enum logic [3:0] {
    S_INIT     = 4'd0,
    S_SET_BOMB = 4'd1,
    S_GAME     = 4'd2,
    S_MOVE     = 4'd3,
    S_REVEAL   = 4'd5,
    S_WIN      = 4'd6,
    S_LOSE     = 4'd7,
    S_FLAG     = 4'd8,
    S_HOLD     = 4'd9
  } state_e;

  state_e         state_q, state_d;
  logic [15:0]    lfsr_q, lfsr_d;
  logic [N-1:0]   bomb_q, bomb_d, rev_q, rev_d, flag_q, flag_d, cur_q, cur_d;
  logic [XW-1:0]  cx_q, cx_d;
  logic [YW-1:0]  cy_q, cy_d;
  logic [FCW-1:0] cnt_q, cnt_d, fc_q, fc_d;
  logic [1:0]     wl_q, wl_d;
  logic           d_en_q, d_en_d, d_cur_q, d_cur_d, d_rev_q, d_rev_d;

  always_comb begin
    logic [IW-1:0] cur_idx;
    logic [IW-1:0] cand;
    logic [N-1:0]  rev_new;
    logic          do_clear;
    int            nx, ny;

    state_d  = state_q;
    lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    bomb_d   = bomb_q;
    rev_d    = rev_q;
    flag_d   = flag_q;
    cur_d    = cur_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    cnt_d    = cnt_q;
    fc_d     = fc_q;
    wl_d     = wl_q;
    d_en_d   = 1'b0;
    d_cur_d  = 1'b0;
    d_rev_d  = 1'b0;
    do_clear = 1'b0;
    cur_idx  = IW'(int'(cy_q) * GRID_W + int'(cx_q));
    cand     = lfsr_q[IW-1:0];
    rev_new  = rev_q;
    nx       = int'(cx_q);
    ny       = int'(cy_q);

    if (bus.restart && state_q != S_INIT) begin
      state_d  = S_INIT;
      do_clear = 1'b1;
    end else begin
      case (state_q)
        S_INIT: begin
          do_clear = 1'b1;
          state_d  = bus.restart ? S_INIT : S_SET_BOMB;
        end
        S_SET_BOMB: begin
          // cell 0 is the start cell and is never mined
          if (cnt_q == '0) begin
            state_d = S_GAME;
          end else if (int'(cand) < N && cand != '0 && !bomb_q[cand]) begin
            bomb_d[cand] = 1'b1;
            cnt_d        = cnt_q - FCW'(1);
            if (cnt_q == FCW'(1)) state_d = S_GAME;
          end
        end
        S_GAME: begin
          if (bus.confirm)      state_d = S_REVEAL;
          else if (bus.flag)    state_d = S_FLAG;
          else if (bus.readkey) state_d = S_MOVE;
        end
        S_REVEAL: begin
          state_d = S_HOLD;
          if (!flag_q[cur_idx] && !rev_q[cur_idx]) begin
            rev_new[cur_idx] = 1'b1;
            d_rev_d          = 1'b1;
            d_en_d           = 1'b1;
            if (bomb_q[cur_idx]) begin
              rev_d   = rev_new | bomb_q;
              wl_d    = 2'b10;
              state_d = S_LOSE;
            end else begin
              rev_d = rev_new;
              if (&(rev_new | bomb_q)) begin
                wl_d    = 2'b01;
                state_d = S_WIN;
              end
            end
          end
        end
        S_FLAG: begin
          state_d = S_HOLD;
          if (!rev_q[cur_idx]) begin
            flag_d[cur_idx] = ~flag_q[cur_idx];
            fc_d = flag_q[cur_idx] ? fc_q - FCW'(1) : fc_q + FCW'(1);
          end
        end
        S_MOVE: begin
          state_d = S_HOLD;
          case (bus.udlr)
            4'b1000: ny = ny - 1;
            4'b0100: ny = ny + 1;
            4'b0010: nx = nx - 1;
            4'b0001: nx = nx + 1;
            default: ;
          endcase
          if (nx < 0)       nx = (WRAP != 0) ? GRID_W - 1 : 0;
          if (nx >= GRID_W) nx = (WRAP != 0) ? 0 : GRID_W - 1;
          if (ny < 0)       ny = (WRAP != 0) ? GRID_H - 1 : 0;
          if (ny >= GRID_H) ny = (WRAP != 0) ? 0 : GRID_H - 1;
          if (nx != int'(cx_q) || ny != int'(cy_q)) begin
            cx_d  = XW'(nx);
            cy_d  = YW'(ny);
            cur_d = '0;
            cur_d[IW'(ny * GRID_W + nx)] = 1'b1;
            d_cur_d = 1'b1;
            d_en_d  = 1'b1;
          end
        end
        S_HOLD: begin
          if (!bus.confirm && !bus.flag && !bus.readkey) state_d = S_GAME;
        end
        default: ;
      endcase
    end

    if (do_clear) begin
      bomb_d = '0;
      rev_d  = '0;
      flag_d = '0;
      cur_d  = {{(N-1){1'b0}}, 1'b1};
      cx_d   = '0;
      cy_d   = '0;
      cnt_d  = FCW'(BOMB_COUNT);
      fc_d   = '0;
      wl_d   = 2'b00;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_INIT;
      lfsr_q  <= LFSR_SEED;
      bomb_q  <= '0;
      rev_q   <= '0;
      flag_q  <= '0;
      cur_q   <= {{(N-1){1'b0}}, 1'b1};
      cx_q    <= '0;
      cy_q    <= '0;
      cnt_q   <= FCW'(BOMB_COUNT);
      fc_q    <= '0;
      wl_q    <= 2'b00;
      d_en_q  <= 1'b0;
      d_cur_q <= 1'b0;
      d_rev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      bomb_q  <= bomb_d;
      rev_q   <= rev_d;
      flag_q  <= flag_d;
      cur_q   <= cur_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      fc_q    <= fc_d;
      wl_q    <= wl_d;
      d_en_q  <= d_en_d;
      d_cur_q <= d_cur_d;
      d_rev_q <= d_rev_d;
    end
  end

  assign bus.wl         = wl_q;
  assign bus.bombGrid   = bomb_q;
  assign bus.revealGrid = rev_q;
  assign bus.flagGrid   = flag_q;
  assign bus.cursorGrid = cur_q;
  assign bus.flag_count = fc_q;
  assign bus.d_enable   = d_en_q;
  assign bus.d_cursor   = d_cur_q;
  assign bus.d_reveal   = d_rev_q;
  assign bus.cs         = state_q;
endmodule

// File: tb/tb_minesweeper_ctrl.sv
// tb/tb_minesweeper_ctrl.sv - randomized and directed bench for minesweeper_ctrl against a board-level model
module tb_minesweeper_ctrl;
  localparam int W = 3, H = 3, N = 9, B = 2, IW = $clog2(N);
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic k_confirm = 1'b0, k_flag = 1'b0, k_restart = 1'b0, k_readkey = 1'b0;
  logic [3:0] k_udlr = 4'b0;
  int sel = 0;

  minesweeper_ctrl_if #(.N(N)) bus0 ();
  minesweeper_ctrl_if #(.N(N)) bus1 ();

  assign bus0.confirm = k_confirm && sel == 0;
  assign bus0.flag    = k_flag    && sel == 0;
  assign bus0.restart = k_restart && sel == 0;
  assign bus0.readkey = k_readkey && sel == 0;
  assign bus0.udlr    = k_udlr;
  assign bus1.confirm = k_confirm && sel == 1;
  assign bus1.flag    = k_flag    && sel == 1;
  assign bus1.restart = k_restart && sel == 1;
  assign bus1.readkey = k_readkey && sel == 1;
  assign bus1.udlr    = k_udlr;

  minesweeper_ctrl #(.GRID_W(W), .GRID_H(H), .BOMB_COUNT(B), .WRAP(0), .LFSR_SEED(SEED))
    dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(bus0));
  minesweeper_ctrl #(.GRID_W(W), .GRID_H(H), .BOMB_COUNT(B), .WRAP(1), .LFSR_SEED(SEED))
    dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(bus1));

  int total = 0;
  int bad = 0;

  // board model: bombs/reveals/flags for instance 0, cursor (x,y) per instance
  logic [15:0] m_lfsr;
  int mcx[2], mcy[2];
  bit [N-1:0] mb, mrev, mflg;
  int mfc, mwl;

  function automatic logic [15:0] lfsr_next(logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_lfsr <= SEED;
    else        m_lfsr <= lfsr_next(m_lfsr);

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] cur_oh(int s);
    return 64'd1 << (mcy[s] * W + mcx[s]);
  endfunction

  task automatic check_reset();
    chk("rst_cs0", bus0.cs, 0);          chk("rst_cs1", bus1.cs, 0);
    chk("rst_bomb0", bus0.bombGrid, 0);  chk("rst_rev0", bus0.revealGrid, 0);
    chk("rst_flag0", bus0.flagGrid, 0);  chk("rst_cur0", bus0.cursorGrid, 1);
    chk("rst_cur1", bus1.cursorGrid, 1); chk("rst_wl0", bus0.wl, 0);
    chk("rst_fc0", bus0.flag_count, 0);
    chk("rst_strobe0", {bus0.d_enable, bus0.d_cursor, bus0.d_reveal}, 0);
  endtask

  // called #1 after the edge that enters SET_BOMB
  task automatic deal(bit both);
    logic [15:0] l;
    int cnt, cyc, c;
    l = m_lfsr; mb = '0; cnt = B; cyc = 0;
    while (cnt > 0 && cyc < 5000) begin
      cyc++;
      c = int'(l) % (1 << IW);
      if (c < N && c != 0 && !mb[c]) begin
        mb[c] = 1'b1;
        cnt--;
      end
      l = lfsr_next(l);
    end
    if (cnt != 0) $fatal(1, "FAIL deal_model no placement within bound");
    repeat (cyc) @(posedge clk);
    #1;
    chk("deal_cs", bus0.cs, 2);
    chk("deal_bombs", bus0.bombGrid, mb);
    chk("deal_pop", $countones(bus0.bombGrid), B);
    chk("deal_safe0", bus0.bombGrid[0], 0);
    chk("deal_cur", bus0.cursorGrid, 1);
    if (both) begin
      chk("deal_cs1", bus1.cs, 2);
      chk("deal_bombs1", bus1.bombGrid, mb);
      mcx[1] = 0; mcy[1] = 0;
    end
    mcx[0] = 0; mcy[0] = 0; mrev = '0; mflg = '0; mfc = 0; mwl = 0;
  endtask

  // kind: 0 = direction key, 1 = flag, 2 = confirm
  task automatic press(int s, int kind, logic [3:0] dir, int hold);
    int exp_cs, i, nx, ny;
    bit ecur, erev, wrap;
    ecur = 1'b0; erev = 1'b0; exp_cs = 9;
    i = mcy[s] * W + mcx[s];
    wrap = (s == 1);
    if (kind == 0) begin
      nx = mcx[s]; ny = mcy[s];
      case (dir)
        4'b1000: ny--;
        4'b0100: ny++;
        4'b0010: nx--;
        4'b0001: nx++;
        default: ;
      endcase
      if (nx < 0)  nx = wrap ? W - 1 : 0;
      if (nx >= W) nx = wrap ? 0 : W - 1;
      if (ny < 0)  ny = wrap ? H - 1 : 0;
      if (ny >= H) ny = wrap ? 0 : H - 1;
      ecur = (nx != mcx[s]) || (ny != mcy[s]);
      mcx[s] = nx; mcy[s] = ny;
    end else if (kind == 1) begin
      if (!mrev[i]) begin
        mflg[i] = ~mflg[i];
        mfc = mflg[i] ? mfc + 1 : mfc - 1;
      end
    end else if (!mflg[i] && !mrev[i]) begin
      mrev[i] = 1'b1;
      erev = 1'b1;
      if (mb[i]) begin
        mrev = mrev | mb; mwl = 2; exp_cs = 7;
      end else if (&(mrev | mb)) begin
        mwl = 1; exp_cs = 6;
      end
    end

    @(negedge clk);
    sel = s; k_udlr = dir;
    k_readkey = (kind == 0); k_flag = (kind == 1); k_confirm = (kind == 2);
    @(posedge clk);
    @(posedge clk);
    #1;
    if (s == 0) begin
      chk("rev", bus0.revealGrid, mrev);
      chk("flg", bus0.flagGrid, mflg);
      chk("fc", bus0.flag_count, mfc);
      chk("wl", bus0.wl, mwl);
      chk("cur", bus0.cursorGrid, cur_oh(0));
      chk("cs", bus0.cs, exp_cs);
      chk("d_cursor", bus0.d_cursor, ecur);
      chk("d_reveal", bus0.d_reveal, erev);
      chk("d_enable", bus0.d_enable, ecur | erev);
    end else begin
      chk("cur1", bus1.cursorGrid, cur_oh(1));
      chk("cs1", bus1.cs, exp_cs);
      chk("d_cursor1", bus1.d_cursor, ecur);
      chk("d_enable1", bus1.d_enable, ecur);
    end
    for (int h = 1; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk("hold_strobe", s == 0 ? bus0.d_enable | bus0.d_cursor : bus1.d_enable | bus1.d_cursor, 0);
      chk("hold_cur", s == 0 ? bus0.cursorGrid : bus1.cursorGrid, cur_oh(s));
    end
    @(negedge clk);
    k_readkey = 1'b0; k_flag = 1'b0; k_confirm = 1'b0; k_udlr = 4'b0;
    @(posedge clk);
    #1;
    chk("after_cs", s == 0 ? bus0.cs : bus1.cs, exp_cs == 9 ? 2 : exp_cs);
    chk("after_strobe", s == 0 ? bus0.d_enable : bus1.d_enable, 0);
  endtask

  task automatic go_to(int tx, int ty);
    while (mcx[0] < tx) press(0, 0, 4'b0001, 1);
    while (mcx[0] > tx) press(0, 0, 4'b0010, 1);
    while (mcy[0] < ty) press(0, 0, 4'b0100, 1);
    while (mcy[0] > ty) press(0, 0, 4'b1000, 1);
  endtask

  task automatic force_loss();
    int b;
    b = -1;
    for (int i = 0; i < N; i++) if (mb[i] && b < 0) b = i;
    go_to(b % W, b / W);
    if (mflg[b]) press(0, 1, 4'b0, 1);
    press(0, 2, 4'b0, 1);
    chk("loss_wl", bus0.wl, 2);
    chk("loss_shown", bus0.revealGrid & mb, mb);
  endtask

  task automatic frozen_check(int exp_cs);
    @(negedge clk);
    sel = 0; k_confirm = 1'b1; k_flag = 1'b1; k_readkey = 1'b1; k_udlr = 4'b0001;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("frz_cs", bus0.cs, exp_cs);
      chk("frz_rev", bus0.revealGrid, mrev);
      chk("frz_flg", bus0.flagGrid, mflg);
      chk("frz_cur", bus0.cursorGrid, cur_oh(0));
      chk("frz_strobe", bus0.d_enable, 0);
    end
    @(negedge clk);
    k_confirm = 1'b0; k_flag = 1'b0; k_readkey = 1'b0; k_udlr = 4'b0;
  endtask

  task automatic restart_game();
    @(negedge clk);
    sel = 0; k_restart = 1'b1;
    @(posedge clk);
    #1;
    chk("rs_cs0", bus0.cs, 0);
    chk("rs_bomb", bus0.bombGrid, 0);
    chk("rs_rev", bus0.revealGrid, 0);
    chk("rs_flag", bus0.flagGrid, 0);
    chk("rs_fc", bus0.flag_count, 0);
    chk("rs_wl", bus0.wl, 0);
    chk("rs_cur", bus0.cursorGrid, 1);
    @(negedge clk);
    k_restart = 1'b0;
    @(posedge clk);
    #1;
    chk("rs_cs1", bus0.cs, 1);
    deal(0);
  endtask

  initial begin
    #2_000_000;
    $fatal(1, "FAIL watchdog time limit reached");
  end

  initial begin
    int r;
    #23;
    check_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("init_exit0", bus0.cs, 1);
    chk("init_exit1", bus1.cs, 1);
    deal(1);

    // edge behaviour: clamp on dut0, wrap on dut1
    press(0, 0, 4'b0010, 1);
    press(0, 0, 4'b1000, 1);
    press(1, 0, 4'b0010, 1);
    chk("wrap_left", bus1.cursorGrid, 9'b000000100);
    press(1, 0, 4'b1000, 1);

    // one move per press, non-one-hot keys ignored
    press(0, 0, 4'b0001, 10);
    chk("one_move", bus0.cursorGrid, 9'b000000010);
    press(0, 0, 4'b0011, 1);

    // flagged cell cannot be revealed
    press(0, 1, 4'b0, 1);
    press(0, 2, 4'b0, 1);
    press(0, 1, 4'b0, 1);

    for (int k = 0; k < 40 && mwl == 0; k++) begin
      r = $urandom_range(0, 5);
      if (r <= 2)      press(0, 0, 4'($urandom_range(0, 15)), 1 + $urandom_range(0, 2));
      else if (r <= 4) press(0, 1, 4'b0, 1);
      else             press(0, 2, 4'b0, 1);
    end
    if (mwl == 0) force_loss();
    frozen_check(mwl == 2 ? 7 : 6);

    restart_game();
    for (int i = 0; i < N; i++) begin
      if (!mb[i]) begin
        go_to(i % W, i / W);
        press(0, 2, 4'b0, 1);
      end
    end
    chk("win_wl", bus0.wl, 1);
    chk("win_cs", bus0.cs, 6);
    frozen_check(6);

    restart_game();
    force_loss();
    chk("lose_cs", bus0.cs, 7);
    frozen_check(7);

    // asynchronous reset in the middle of a deal
    @(negedge clk);
    k_restart = 1'b1;
    @(posedge clk);
    @(negedge clk);
    k_restart = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_cs1", bus0.cs, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
